mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-master arbiter that shares the single synchronous byte-wide memory port between the cpu (master 0) and a second bus master such as the program loader or debug port (master 1). It grants the port round-robin, one access per grant. A lock input lets a master keep the port for multi-byte sequences such as a 4-byte instruction fetch, and a hold limit stops a locked master from starving the other. It sits between the masters and the memory model, and drives the memory's addr/di/do/we.

## Interface
- AW, 16, address width
- DW, 8, data width
- MAX_HOLD, 8, max consecutive owned cycles while the other master waits (≥2)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- mN_req  in  1  master N (N=0,1) requests an access this cycle
- mN_lock  in  1  master N keeps ownership after this access
- mN_addr  in  AW  access address
- mN_wdata  in  DW  write data
- mN_we  in  1  1=write, 0=read
- mN_gnt  out  1  master N owns the port
- mN_rvalid  out  1  read data valid for master N
- mN_rdata  out  DW  read data
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_we  out  1  memory write enable
- mem_rdata  in  DW  memory read data, valid one cycle after address (synchronous read)

## Operation
- FSM states: IDLE, OWN0, OWN1. `gnt_N = (state==OWNN)`.
- Register `last`: the last owner. Reset value 1, so master 0 wins the first tie.
- IDLE:
  - req0 only -> OWN0.
  - req1 only -> OWN1.
  - Both -> OWN of the master ≠ last.
  - Neither -> stay.
- Access cycle: state==OWNN && mN_req. mem_addr/mem_wdata come from master N; mem_we = mN_we.
- Outside access cycles: mem_we=0, and mem_addr/mem_wdata=0.
- Exit from OWNN, evaluated each cycle:
  - mN_lock=1 and hold_cnt < MAX_HOLD-1 -> stay in OWNN. This holds even if mN_req=0, so the master can idle while keeping the port.
  - mN_lock=1, hold_cnt == MAX_HOLD-1, and the other req=1 -> forced release.
  - mN_lock=0, or forced release -> go to OWN(other) if the other req=1, else IDLE.
  - In every exit case, last <= N.
- hold_cnt:
  - Clears on entry to any OWN state.
  - Increments every cycle in OWN while the other master's req=1.
  - Saturates at MAX_HOLD-1.
  - Without contention, lock holds the port indefinitely.
- Read return: registered `rv_src`/`rv_pend` capture each read access. The following cycle, mN_rvalid=1 for the captured master, and mN_rdata = mem_rdata.
- mN_rdata is held between valids. Writes produce no rvalid.

## Timing
- Reset values: state IDLE, both gnt 0, both rvalid 0, both rdata 0, last=1, hold_cnt 0, rv_pend 0, mem_we 0.
- Reset asserted mid-operation drops any pending rvalid. A write in progress that cycle is not committed (mem_we forced 0 asynchronously via the state).
- Grant latency from IDLE: req seen at edge k -> gnt high in cycle k+1 -> access in cycle k+1.
- Read latency: access cycle c -> rvalid in cycle c+1.
- Back-to-back handover: an unlocked access by N in cycle c with the other requesting -> the other owns from cycle c+1. There is no IDLE bubble.
- A master must hold addr/wdata/we stable while req=1 and gnt=0.
- A master may change addr/wdata/we every cycle while granted.
- Both gnt outputs are never high together. mem_we is never high outside an access cycle.

## Test plan
- Reset release, then m0 reads addr 0x0010 (mem=0xA5): m0_gnt the next cycle, m0_rvalid one cycle after the access, m0_rdata=0xA5. m1 signals untouched.
- Simultaneous single reads from both masters after reset: m0 is served first, m1 on the following cycle. Repeating the collision serves m1 first (alternation).
- m0 locked 4-byte read at 0x0000–0x0003 (bytes 0x01,0x02,0x03,0x04) while m1 requests: m1 waits. m0 gets 4 rvalids with 01,02,03,04 on consecutive cycles. m1 is granted the cycle after m0's unlocked last access.
- m0 holds lock with MAX_HOLD=8 while m1 requests: m0 is forcibly released after 8 owned cycles, and m1_gnt rises in the next cycle. Without an m1 request, m0 stays owner for 20 or more cycles.
- m1 writes 0x5A to 0x1234, then m0 reads 0x1234: mem_we pulses for exactly 1 cycle with mem_addr=0x1234. m0_rdata=0x5A. m1_rvalid never asserts.
- Assert rst during the cycle after a read access: rvalid stays 0, both gnt are 0, and after release the tie-break again favors m0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one synchronous byte-wide memory port between two masters,
// with per-master lock for multi-byte sequences and a hold limit under contention.
module mem_arbiter #(
   parameter int AW       = 16,
   parameter int DW       = 8,
   parameter int MAX_HOLD = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_m0_req,
   input  logic          i_m0_lock,
   input  logic [AW-1:0] i_m0_addr,
   input  logic [DW-1:0] i_m0_wdata,
   input  logic          i_m0_we,
   output logic          o_m0_gnt,
   output logic          o_m0_rvalid,
   output logic [DW-1:0] o_m0_rdata,
   input  logic          i_m1_req,
   input  logic          i_m1_lock,
   input  logic [AW-1:0] i_m1_addr,
   input  logic [DW-1:0] i_m1_wdata,
   input  logic          i_m1_we,
   output logic          o_m1_gnt,
   output logic          o_m1_rvalid,
   output logic [DW-1:0] o_m1_rdata,
   output logic [AW-1:0] o_mem_addr,
   output logic [DW-1:0] o_mem_wdata,
   output logic          o_mem_we,
   input  logic [DW-1:0] i_mem_rdata
);

   localparam int HW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
   localparam logic [HW-1:0] HOLD_TOP = HW'(MAX_HOLD - 1);

   typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

   state_t        r_state, w_next;
   logic          r_last, w_last_next;
   logic [HW-1:0] r_hold, w_hold_next;
   logic          r_rv_pend, r_rv_src;
   logic [DW-1:0] r_m0_rdata, r_m1_rdata;

   logic          w_own, w_own_id, w_req_own, w_lock_own, w_req_oth, w_access, w_we_own;

   assign w_own      = (r_state != IDLE);
   assign w_own_id   = (r_state == OWN1);
   assign w_req_own  = w_own_id ? i_m1_req  : i_m0_req;
   assign w_lock_own = w_own_id ? i_m1_lock : i_m0_lock;
   assign w_we_own   = w_own_id ? i_m1_we   : i_m0_we;
   assign w_req_oth  = w_own_id ? i_m0_req  : i_m1_req;
   assign w_access   = w_own && w_req_own;

   assign o_m0_gnt = (r_state == OWN0);
   assign o_m1_gnt = (r_state == OWN1);

   // Memory port is driven only during an access cycle; zeros otherwise.
   always_comb begin
      o_mem_addr  = '0;
      o_mem_wdata = '0;
      o_mem_we    = 1'b0;
      if (w_access) begin
         o_mem_addr  = w_own_id ? i_m1_addr  : i_m0_addr;
         o_mem_wdata = w_own_id ? i_m1_wdata : i_m0_wdata;
         o_mem_we    = w_we_own;
      end
   end

   always_comb begin
      w_next      = r_state;
      w_last_next = r_last;
      w_hold_next = r_hold;
      case (r_state)
         IDLE: begin
            if (i_m0_req && (!i_m1_req || r_last))
               w_next = OWN0;
            else if (i_m1_req)
               w_next = OWN1;
         end
         default: begin
            if (w_req_oth && (r_hold != HOLD_TOP))
               w_hold_next = r_hold + 1'b1;
            // A lock survives at the limit only while nobody else is waiting.
            if (!(w_lock_own && ((r_hold != HOLD_TOP) || !w_req_oth))) begin
               w_last_next = w_own_id;
               if (w_req_oth)
                  w_next = w_own_id ? OWN0 : OWN1;
               else
                  w_next = IDLE;
            end
         end
      endcase
      if (w_next != r_state)
         w_hold_next = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_last    <= 1'b1;
         r_hold    <= '0;
         r_rv_pend <= 1'b0;
         r_rv_src  <= 1'b0;
      end else begin
         r_state   <= w_next;
         r_last    <= w_last_next;
         r_hold    <= w_hold_next;
         r_rv_pend <= w_access && !w_we_own;
         r_rv_src  <= w_own_id;
      end
   end

   // Read return stage: memory data arrives the cycle after the access.
   assign o_m0_rvalid = r_rv_pend && !r_rv_src;
   assign o_m1_rvalid = r_rv_pend &&  r_rv_src;
   assign o_m0_rdata  = o_m0_rvalid ? i_mem_rdata : r_m0_rdata;
   assign o_m1_rdata  = o_m1_rvalid ? i_mem_rdata : r_m1_rdata;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_m0_rdata <= '0;
         r_m1_rdata <= '0;
      end else begin
         if (o_m0_rvalid) r_m0_rdata <= i_mem_rdata;
         if (o_m1_rvalid) r_m1_rdata <= i_mem_rdata;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural synchronous-read byte memory.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        m0_req = 0, m0_lock = 0, m0_we = 0;
   logic [15:0] m0_addr = 0;
   logic [7:0]  m0_wdata = 0;
   logic        m1_req = 0, m1_lock = 0, m1_we = 0;
   logic [15:0] m1_addr = 0;
   logic [7:0]  m1_wdata = 0;
   logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
   logic [7:0]  m0_rdata, m1_rdata;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_we;
   logic [7:0]  mem_rdata = 0;

   logic [7:0]  mem [0:65535];

   int n_tests = 0;
   int n_fail  = 0;
   int we_cnt  = 0;
   int rv1_cnt = 0;
   int bad_cnt = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.AW(16), .DW(8), .MAX_HOLD(8)) dut (
      .clk(clk), .rst(rst),
      .i_m0_req(m0_req), .i_m0_lock(m0_lock), .i_m0_addr(m0_addr), .i_m0_wdata(m0_wdata), .i_m0_we(m0_we),
      .o_m0_gnt(m0_gnt), .o_m0_rvalid(m0_rvalid), .o_m0_rdata(m0_rdata),
      .i_m1_req(m1_req), .i_m1_lock(m1_lock), .i_m1_addr(m1_addr), .i_m1_wdata(m1_wdata), .i_m1_we(m1_we),
      .o_m1_gnt(m1_gnt), .o_m1_rvalid(m1_rvalid), .o_m1_rdata(m1_rdata),
      .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_we(mem_we),
      .i_mem_rdata(mem_rdata)
   );

   always @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
   end

   always @(posedge clk) begin
      if (mem_we) we_cnt <= we_cnt + 1;
      if (m1_rvalid) rv1_cnt <= rv1_cnt + 1;
      if ((m0_gnt && m1_gnt) || (mem_we && !((m0_gnt && m0_req) || (m1_gnt && m1_req))))
         bad_cnt <= bad_cnt + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #1;
      n_tests++; if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0) begin n_fail++; $display("FAIL reset_gnt: got %b%b expected 00", m0_gnt, m1_gnt); end
      n_tests++; if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b%b expected 00", m0_rvalid, m1_rvalid); end
      n_tests++; if (m0_rdata !== 8'h00 || m1_rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rdata: got %h/%h expected 00/00", m0_rdata, m1_rdata); end
      n_tests++; if (mem_we !== 1'b0 || mem_addr !== 16'h0000) begin n_fail++; $display("FAIL reset_mem: got we=%b addr=%h expected 0/0000", mem_we, mem_addr); end
      tick(); tick();
      rst = 1'b0;
   endtask

   task automatic test_m0_read();
      m0_addr = 16'h0010; m0_we = 0; m0_req = 1;
      tick(); #1;
      n_tests++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin n_fail++; $display("FAIL read_gnt: got %b%b expected 10", m0_gnt, m1_gnt); end
      n_tests++; if (mem_addr !== 16'h0010 || mem_we !== 1'b0) begin n_fail++; $display("FAIL read_addr: got %h we=%b expected 0010 we=0", mem_addr, mem_we); end
      tick(); m0_req = 0; #1;
      n_tests++; if (m0_rvalid !== 1'b1 || m0_rdata !== 8'hA5) begin n_fail++; $display("FAIL read_data: got v=%b %h expected v=1 a5", m0_rvalid, m0_rdata); end
      n_tests++; if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0 || m1_rvalid !== 1'b0) begin n_fail++; $display("FAIL read_after: got g0=%b g1=%b v1=%b expected 000", m0_gnt, m1_gnt, m1_rvalid); end
   endtask

   task automatic test_collision();
      rst = 1; tick(); rst = 0;
      m0_addr = 16'h0020; m1_addr = 16'h0021; m0_req = 1; m1_req = 1;
      tick(); #1;
      n_tests++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0 || mem_addr !== 16'h0020) begin n_fail++; $display("FAIL coll1_first: got g=%b%b addr=%h expected 10 0020", m0_gnt, m1_gnt, mem_addr); end
      tick(); m0_req = 0; #1;
      n_tests++; if (m1_gnt !== 1'b1 || m0_gnt !== 1'b0 || mem_addr !== 16'h0021) begin n_fail++; $display("FAIL coll1_second: got g=%b%b addr=%h expected 01 0021", m0_gnt, m1_gnt, mem_addr); end
      n_tests++; if (m0_rvalid !== 1'b1 || m0_rdata !== 8'h11) begin n_fail++; $display("FAIL coll1_rd0: got v=%b %h expected v=1 11", m0_rvalid, m0_rdata); end
      tick(); m1_req = 0; #1;
      n_tests++; if (m1_rvalid !== 1'b1 || m1_rdata !== 8'h22 || m0_rvalid !== 1'b0) begin n_fail++; $display("FAIL coll1_rd1: got v1=%b %h v0=%b expected 1 22 0", m1_rvalid, m1_rdata, m0_rvalid); end
      m0_addr = 16'h0022; m0_req = 1;
      tick(); tick(); m0_req = 0; #1;
      n_tests++; if (m0_rvalid !== 1'b1 || m0_rdata !== 8'h33) begin n_fail++; $display("FAIL solo_rd0: got v=%b %h expected v=1 33", m0_rvalid, m0_rdata); end
      m0_addr = 16'h0020; m0_req = 1; m1_req = 1;
      tick(); #1;
      n_tests++; if (m1_gnt !== 1'b1 || m0_gnt !== 1'b0) begin n_fail++; $display("FAIL coll2_first: got g=%b%b expected 01", m0_gnt, m1_gnt); end
      tick(); m1_req = 0; #1;
      n_tests++; if (m0_gnt !== 1'b1 || m1_rvalid !== 1'b1 || m1_rdata !== 8'h22) begin n_fail++; $display("FAIL coll2_second: got g0=%b v1=%b %h expected 1 1 22", m0_gnt, m1_rvalid, m1_rdata); end
      tick(); m0_req = 0; #1;
      n_tests++; if (m0_rvalid !== 1'b1 || m0_rdata !== 8'h11 || m0_gnt !== 1'b0) begin n_fail++; $display("FAIL coll2_rd0: got v=%b %h g0=%b expected 1 11 0", m0_rvalid, m0_rdata, m0_gnt); end
   endtask

   task automatic test_lock_burst();
      m0_addr = 16'h0000; m0_lock = 1; m0_req = 1;
      tick();
      m1_addr = 16'h0021; m1_req = 1;
      for (int i = 0; i < 4; i++) begin
         m0_addr = 16'(i); m0_lock = (i < 3); #1;
         n_tests++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0 || mem_addr !== 16'(i)) begin n_fail++; $display("FAIL burst_own%0d: got g=%b%b addr=%h expected 10 %h", i, m0_gnt, m1_gnt, mem_addr, 16'(i)); end
         if (i > 0) begin
            n_tests++; if (m0_rvalid !== 1'b1 || m0_rdata !== 8'(i)) begin n_fail++; $display("FAIL burst_rd%0d: got v=%b %h expected v=1 %h", i, m0_rvalid, m0_rdata, 8'(i)); end
         end
         tick();
      end
      m0_req = 0; m0_lock = 0; #1;
      n_tests++; if (m1_gnt !== 1'b1 || m0_gnt !== 1'b0) begin n_fail++; $display("FAIL burst_handover: got g=%b%b expected 01", m0_gnt, m1_gnt); end
      n_tests++; if (m0_rvalid !== 1'b1 || m0_rdata !== 8'h04) begin n_fail++; $display("FAIL burst_rd4: got v=%b %h expected v=1 04", m0_rvalid, m0_rdata); end
      tick(); m1_req = 0; #1;
      n_tests++; if (m1_rvalid !== 1'b1 || m1_rdata !== 8'h22 || m1_gnt !== 1'b0) begin n_fail++; $display("FAIL burst_m1rd: got v=%b %h g1=%b expected 1 22 0", m1_rvalid, m1_rdata, m1_gnt); end
   endtask

   task automatic test_hold_limit();
      m0_addr = 16'h0000; m0_lock = 1; m0_req = 1; m1_addr = 16'h0021; m1_req = 1;
      tick();
      for (int j = 0; j < 8; j++) begin
         #1;
         n_tests++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin n_fail++; $display("FAIL hold_own%0d: got g=%b%b expected 10", j, m0_gnt, m1_gnt); end
         tick();
      end
      m0_req = 0; m0_lock = 0; #1;
      n_tests++; if (m1_gnt !== 1'b1 || m0_gnt !== 1'b0) begin n_fail++; $display("FAIL hold_release: got g=%b%b expected 01", m0_gnt, m1_gnt); end
      tick(); m1_req = 0; #1;
      n_tests++; if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0) begin n_fail++; $display("FAIL hold_idle: got g=%b%b expected 00", m0_gnt, m1_gnt); end
      m0_lock = 1; m0_req = 1;
      tick(); m0_req = 0;
      for (int j = 0; j < 22; j++) begin
         #1;
         n_tests++; if (m0_gnt !== 1'b1) begin n_fail++; $display("FAIL lock_keep%0d: got g0=%b expected 1", j, m0_gnt); end
         tick();
      end
      m0_lock = 0;
      tick(); #1;
      n_tests++; if (m0_gnt !== 1'b0) begin n_fail++; $display("FAIL lock_drop: got g0=%b expected 0", m0_gnt); end
   endtask

   task automatic test_write_then_read();
      int w0, r0;
      w0 = we_cnt; r0 = rv1_cnt;
      m1_addr = 16'h1234; m1_wdata = 8'h5A; m1_we = 1; m1_req = 1;
      tick(); #1;
      n_tests++; if (m1_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 16'h1234 || mem_wdata !== 8'h5A) begin n_fail++; $display("FAIL wr_access: got g1=%b we=%b addr=%h wd=%h expected 1 1 1234 5a", m1_gnt, mem_we, mem_addr, mem_wdata); end
      tick(); m1_req = 0; m1_we = 0; #1;
      n_tests++; if (mem_we !== 1'b0 || m1_rvalid !== 1'b0 || mem_addr !== 16'h0000) begin n_fail++; $display("FAIL wr_after: got we=%b v1=%b addr=%h expected 0 0 0000", mem_we, m1_rvalid, mem_addr); end
      m0_addr = 16'h1234; m0_req = 1;
      tick(); #1;
      n_tests++; if (m0_gnt !== 1'b1 || mem_we !== 1'b0) begin n_fail++; $display("FAIL wr_rdgnt: got g0=%b we=%b expected 1 0", m0_gnt, mem_we); end
      tick(); m0_req = 0; #1;
      n_tests++; if (m0_rvalid !== 1'b1 || m0_rdata !== 8'h5A) begin n_fail++; $display("FAIL wr_readback: got v=%b %h expected v=1 5a", m0_rvalid, m0_rdata); end
      n_tests++; if (we_cnt - w0 !== 1) begin n_fail++; $display("FAIL wr_pulses: got %0d expected 1", we_cnt - w0); end
      n_tests++; if (rv1_cnt - r0 !== 0) begin n_fail++; $display("FAIL wr_m1rvalid: got %0d expected 0", rv1_cnt - r0); end
   endtask

   task automatic test_reset_mid();
      m0_addr = 16'h0010; m0_req = 1;
      tick(); #1;
      n_tests++; if (m0_gnt !== 1'b1) begin n_fail++; $display("FAIL rstmid_gnt: got g0=%b expected 1", m0_gnt); end
      tick();
      m0_addr = 16'h0020; m1_addr = 16'h0021; m0_req = 1; m1_req = 1; rst = 1; #1;
      n_tests++; if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin n_fail++; $display("FAIL rstmid_rvalid: got %b%b expected 00", m0_rvalid, m1_rvalid); end
      n_tests++; if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0 || mem_we !== 1'b0) begin n_fail++; $display("FAIL rstmid_gnt0: got g=%b%b we=%b expected 00 0", m0_gnt, m1_gnt, mem_we); end
      n_tests++; if (m0_rdata !== 8'h00) begin n_fail++; $display("FAIL rstmid_rdata: got %h expected 00", m0_rdata); end
      tick(); #1;
      n_tests++; if (m0_rvalid !== 1'b0 || m0_gnt !== 1'b0) begin n_fail++; $display("FAIL rstmid_hold: got v0=%b g0=%b expected 0 0", m0_rvalid, m0_gnt); end
      tick(); rst = 0;
      tick(); #1;
      n_tests++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin n_fail++; $display("FAIL rstmid_tiebreak: got g=%b%b expected 10", m0_gnt, m1_gnt); end
      m0_req = 0;
      tick(); m1_req = 0;
      tick(); #1;
   endtask

   initial begin
      for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
      mem[16'h0010] = 8'hA5;
      mem[16'h0000] = 8'h01; mem[16'h0001] = 8'h02; mem[16'h0002] = 8'h03; mem[16'h0003] = 8'h04;
      mem[16'h0020] = 8'h11; mem[16'h0021] = 8'h22; mem[16'h0022] = 8'h33;
      test_reset();
      test_m0_read();
      test_collision();
      test_lock_burst();
      test_hold_limit();
      test_write_then_read();
      test_reset_mid();
      n_tests++; if (bad_cnt !== 0) begin n_fail++; $display("FAIL invariants: got %0d violating cycles expected 0", bad_cnt); end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
